mlp_dram_loader: RTL and testbench
==================================

# mlp_dram_loader

Upstream/downstream memory engine for the MLP `Top` core. It fetches ifmap, weight and bias words from a word-addressed external memory and streams them into `Top` over the `ready`/`i_en`/`data_in` interface. It then captures `Top`'s `valid`/`ofmap` results and writes them back to memory. One `start` runs a complete two-pass job for mode 0 (MLP0) or mode 1 (MLP3).

## Interface
- ADDR_W, 16, word-address width
- IFMAP_WORDS, 16, packed ifmap words per pass (4 bytes per word)
- WEIGHT_WORDS, 1024, packed weight words per pass
- BIAS_WORDS, 64, bias words per pass
- OFMAP_WORDS, 64, result words per pass
- FIFO_DEPTH, 4, write-back FIFO depth (power of 2)

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle job request; ignored while busy=1
- mode  in  1  0 = MLP0, 1 = MLP3; sampled on an accepted start
- ifmap_base, weight_base, bias_base, ofmap_base  in  ADDR_W each  region word bases; sampled on an accepted start
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data
- mem_gnt  in  1  request accepted this cycle
- mem_rdata  in  32  read data, valid exactly 1 cycle after a read is granted
- top_ready  out  1  one-cycle pass-start pulse to Top
- top_i_en  out  1  data_in qualifier to Top
- top_data_in  out  32  streamed word
- top_valid  in  1  Top result strobe
- top_ofmap  in  32  Top result word
- busy  out  1  high from an accepted start until done
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky write-FIFO overflow flag; cleared by an accepted start

## Operation
- States: IDLE -> WAIT_Q -> RDY -> LOAD -> DRAIN -> COLLECT -> (WAIT_Q with pass=1 | FIN) -> IDLE.
- IDLE: on start, latch the inputs, set pass=0, set busy, clear err.
- WAIT_Q: hold until top_valid=0, then go to RDY.
- RDY: drive top_ready=1 for exactly one cycle, then go to LOAD.
- LOAD: issue L = IFMAP_WORDS + WEIGHT_WORDS + BIAS_WORDS = 1104 reads, in order ifmap, weight, bias, with rd index k per region.
  - mem_req stays high and mem_addr stays stable until mem_gnt.
  - After the last grant, go to DRAIN.
- Read addresses, ifmap:
  - mode 0: ifmap_base + k.
  - mode 1: ifmap_base + 16·pass + k.
- Read addresses, weight (mode 1 treats the region as 128-wide rows of 32 words: r = k>>4, c = k[3:0]):
  - mode 0: weight_base + 1024·pass + k.
  - mode 1: weight_base + 32·r + 16·pass + c.
- Read addresses, bias:
  - mode 0: bias_base + 64·pass + k.
  - mode 1, pass 0: bias_base + k.
  - mode 1, pass 1: ofmap_base + k (the pass-0 partial sums).
- Each rdata beat is registered into top_data_in with top_i_en=1. Grant gaps produce i_en gaps; Top counts only i_en cycles.
- DRAIN: wait until the final i_en beat has been driven, then go to COLLECT.
- COLLECT: each top_valid=1 cycle pushes top_ofmap into the FIFO.
  - Write address, mode 0: ofmap_base + 64·pass + j.
  - Write address, mode 1: ofmap_base + 64·pass + j (pass 0 partials at +0, pass 1 finals at +64).
  - The FIFO head drives a write request (mem_we=1) until granted.
  - Leave COLLECT when OFMAP_WORDS words have been pushed and the FIFO is empty and the last write is granted.
- End of pass: pass 0 goes to WAIT_Q with pass=1; pass 1 goes to FIN.
- FIN: pulse done, clear busy, return to IDLE.
- Overflow: top_valid while the FIFO is full drops the word, sets err, and still increments j, so the job terminates.
- Reads and writes never overlap by construction. If both are pending, the write wins.
- Counters: rd index 11 bit, j 7 bit. Addresses wrap modulo 2^ADDR_W with no error.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, top_ready=0, top_i_en=0, top_data_in=0, busy=0, done=0, err=0. State = IDLE, pass=0, FIFO empty.
- Reset mid-job aborts immediately: every output returns to its reset value and no further memory request is made.
- start→busy: 1 cycle. The first mem_req is asserted 2 cycles after RDY's top_ready pulse at the earliest (RDY→LOAD).
- Read grant at cycle t → top_i_en/top_data_in at cycle t+2.
- With mem_gnt tied high, a pass's i_en stream is 1104 consecutive cycles.
- Write latency: a push at cycle t can be requested at t+1.
- A start received while busy=1 is ignored, and err is not cleared by it.

## Test plan
- Mode 0, mem_gnt=1, bases 0/0x100/0x900/0xA00: exactly 2×1104 i_en beats in order. Pass 1 weight addresses start at 0x500 and bias at 0x940. Results land at 0xA00–0xA7F. done fires once and busy falls the same cycle.
- Mode 1, weight_base=0x100: pass 0 weight address sequence 0x100..0x10F, then 0x120. Pass 1 starts at 0x110. Pass 1 bias reads 0xA00.. return the written pass-0 results.
- Random mem_gnt (50%): top_data_in order matches the gnt=1 run, and mem_addr is stable across stalled cycles.
- mem_gnt=0 throughout COLLECT with 5 top_valid strobes: err=1, four words are retained, and the job still finishes after gnt returns.
- rst_n low mid-LOAD at read 500: outputs are at reset values within the reset cycle. A new start restarts from read 0.
- start pulsed while busy: no effect. top_ready is pulsed only after top_valid is low.

Source files
------------

// File: rtl/mlp_dram_loader.sv
// mlp_dram_loader: memory engine for the MLP Top core. For each of two passes
// it streams ifmap, weight and bias words from word-addressed memory into Top.
// It then buffers Top's results in a small FIFO and writes them back to memory.
module mlp_dram_loader #(
   parameter int ADDR_W       = 16,
   parameter int IFMAP_WORDS  = 16,
   parameter int WEIGHT_WORDS = 1024,
   parameter int BIAS_WORDS   = 64,
   parameter int OFMAP_WORDS  = 64,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] ifmap_base,
   input  logic [ADDR_W-1:0] weight_base,
   input  logic [ADDR_W-1:0] bias_base,
   input  logic [ADDR_W-1:0] ofmap_base,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_gnt,
   input  logic [31:0]       mem_rdata,
   output logic              top_ready,
   output logic              top_i_en,
   output logic [31:0]       top_data_in,
   input  logic              top_valid,
   input  logic [31:0]       top_ofmap,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int RD_W  = 11;
   localparam int J_W   = 7;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [RD_W-1:0] WGT_START  = RD_W'(IFMAP_WORDS);
   localparam logic [RD_W-1:0] BIAS_START = RD_W'(IFMAP_WORDS + WEIGHT_WORDS);
   localparam logic [RD_W-1:0] LOAD_WORDS = RD_W'(IFMAP_WORDS + WEIGHT_WORDS + BIAS_WORDS);
   localparam logic [J_W-1:0]  OFM_WORDS  = J_W'(OFMAP_WORDS);
   localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_Q, S_RDY, S_LOAD, S_DRAIN, S_COLLECT, S_FIN
   } state_e;

   state_e            state_q, state_d;
   logic              pass_q, pass_d;
   logic              mode_q, mode_d;
   logic [ADDR_W-1:0] ifmap_base_q, ifmap_base_d;
   logic [ADDR_W-1:0] weight_base_q, weight_base_d;
   logic [ADDR_W-1:0] bias_base_q, bias_base_d;
   logic [ADDR_W-1:0] ofmap_base_q, ofmap_base_d;
   logic [RD_W-1:0]   rd_cnt_q, rd_cnt_d;
   logic              rd_req_q, rd_req_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              rd_pend_q, rd_pend_d;
   logic              top_i_en_q, top_i_en_d;
   logic [31:0]       top_data_q, top_data_d;
   logic [J_W-1:0]    j_q, j_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic [31:0]       fifo_data_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];

   logic              wr_req, wr_fire, rd_fire;
   logic              push_try, push, fifo_full;
   logic [RD_W-1:0]   rd_cnt_nxt, k;
   logic [ADDR_W-1:0] rd_addr_nxt, wr_addr;

   // Handshake qualifiers; a pending write always takes the port ahead of a read.
   always_comb begin
      wr_req     = (fifo_cnt_q != '0);
      wr_fire    = wr_req & mem_gnt;
      rd_fire    = rd_req_q & mem_gnt & ~wr_req;
      rd_cnt_nxt = rd_cnt_q + RD_W'(rd_fire);
      fifo_full  = (fifo_cnt_q == FIFO_FULL);
      push_try   = (state_q == S_COLLECT) && top_valid && (j_q < OFM_WORDS);
      push       = push_try && !fifo_full;
      wr_addr    = ofmap_base_q + ADDR_W'(j_q) + (pass_q ? ADDR_W'(OFMAP_WORDS) : '0);
   end

   // Address of read number rd_cnt_nxt, split into ifmap / weight / bias regions.
   always_comb begin
      k           = '0;
      rd_addr_nxt = '0;
      if (rd_cnt_nxt < WGT_START) begin
         k           = rd_cnt_nxt;
         rd_addr_nxt = ifmap_base_q + ADDR_W'(k)
                     + ((mode_q && pass_q) ? ADDR_W'(IFMAP_WORDS) : '0);
      end else if (rd_cnt_nxt < BIAS_START) begin
         k = rd_cnt_nxt - WGT_START;
         if (mode_q) begin
            // 32-word rows; each pass takes one 16-word half of every row.
            rd_addr_nxt = weight_base_q + (ADDR_W'(k >> 4) << 5) + ADDR_W'(k[3:0])
                        + (pass_q ? ADDR_W'(16) : '0);
         end else begin
            rd_addr_nxt = weight_base_q + ADDR_W'(k)
                        + (pass_q ? ADDR_W'(WEIGHT_WORDS) : '0);
         end
      end else begin
         k = rd_cnt_nxt - BIAS_START;
         if (mode_q) begin
            // Second MLP3 pass takes its bias from the first pass's partial sums.
            rd_addr_nxt = (pass_q ? ofmap_base_q : bias_base_q) + ADDR_W'(k);
         end else begin
            rd_addr_nxt = bias_base_q + ADDR_W'(k)
                        + (pass_q ? ADDR_W'(BIAS_WORDS) : '0);
         end
      end
   end

   // Next-state and register updates for the job sequencer and datapath.
   always_comb begin
      state_d       = state_q;
      pass_d        = pass_q;
      mode_d        = mode_q;
      ifmap_base_d  = ifmap_base_q;
      weight_base_d = weight_base_q;
      bias_base_d   = bias_base_q;
      ofmap_base_d  = ofmap_base_q;
      rd_cnt_d      = rd_cnt_q;
      rd_req_d      = 1'b0;
      rd_addr_d     = rd_addr_q;
      rd_pend_d     = rd_fire;
      top_i_en_d    = rd_pend_q;
      top_data_d    = rd_pend_q ? mem_rdata : top_data_q;
      j_d           = j_q;
      wr_ptr_d      = wr_ptr_q + PTR_W'(push);
      rd_ptr_d      = rd_ptr_q + PTR_W'(wr_fire);
      fifo_cnt_d    = fifo_cnt_q + CNT_W'(push) - CNT_W'(wr_fire);
      busy_d        = busy_q;
      done_d        = (state_q == S_FIN);
      err_d         = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d        = mode;
               ifmap_base_d  = ifmap_base;
               weight_base_d = weight_base;
               bias_base_d   = bias_base;
               ofmap_base_d  = ofmap_base;
               pass_d        = 1'b0;
               busy_d        = 1'b1;
               err_d         = 1'b0;
               state_d       = S_WAIT_Q;
            end
         end
         S_WAIT_Q: begin
            if (!top_valid) state_d = S_RDY;
         end
         S_RDY: begin
            rd_cnt_d = '0;
            j_d      = '0;
            state_d  = S_LOAD;
         end
         S_LOAD: begin
            rd_cnt_d = rd_cnt_nxt;
            if (rd_cnt_nxt == LOAD_WORDS) begin
               state_d = S_DRAIN;
            end else begin
               rd_req_d  = 1'b1;
               rd_addr_d = rd_addr_nxt;
            end
         end
         S_DRAIN: begin
            // Last grant is still in flight until its beat reaches top_i_en.
            if (top_i_en_q && !rd_pend_q) state_d = S_COLLECT;
         end
         S_COLLECT: begin
            // Dropped words still advance j so the pass always terminates.
            j_d = j_q + J_W'(push_try);
            if (push_try && fifo_full) err_d = 1'b1;
            if (j_q == OFM_WORDS && fifo_cnt_q == '0) begin
               if (pass_q) begin
                  state_d = S_FIN;
               end else begin
                  pass_d  = 1'b1;
                  state_d = S_WAIT_Q;
               end
            end
         end
         S_FIN: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and datapath registers.
   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pass_q        <= 1'b0;
         mode_q        <= 1'b0;
         ifmap_base_q  <= '0;
         weight_base_q <= '0;
         bias_base_q   <= '0;
         ofmap_base_q  <= '0;
         rd_cnt_q      <= '0;
         rd_req_q      <= 1'b0;
         rd_addr_q     <= '0;
         rd_pend_q     <= 1'b0;
         top_i_en_q    <= 1'b0;
         top_data_q    <= '0;
         j_q           <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fifo_cnt_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         pass_q        <= pass_d;
         mode_q        <= mode_d;
         ifmap_base_q  <= ifmap_base_d;
         weight_base_q <= weight_base_d;
         bias_base_q   <= bias_base_d;
         ofmap_base_q  <= ofmap_base_d;
         rd_cnt_q      <= rd_cnt_d;
         rd_req_q      <= rd_req_d;
         rd_addr_q     <= rd_addr_d;
         rd_pend_q     <= rd_pend_d;
         top_i_en_q    <= top_i_en_d;
         top_data_q    <= top_data_d;
         j_q           <= j_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fifo_cnt_q    <= fifo_cnt_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

   // Write-back FIFO storage.
   // NOTE: storage has no reset; entries are only observed once the count covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= top_ofmap;
         fifo_addr_q[wr_ptr_q] <= wr_addr;
      end
   end

   // Memory port and Top-facing outputs; idle values are forced to zero.
   always_comb begin
      mem_req     = wr_req | rd_req_q;
      mem_we      = wr_req;
      mem_addr    = wr_req ? fifo_addr_q[rd_ptr_q] : (rd_req_q ? rd_addr_q : '0);
      mem_wdata   = wr_req ? fifo_data_q[rd_ptr_q] : '0;
      top_ready   = (state_q == S_RDY);
      top_i_en    = top_i_en_q;
      top_data_in = top_data_q;
      busy        = busy_q;
      done        = done_q;
      err         = err_q;
   end

endmodule

// File: tb/tb_mlp_dram_loader.sv
// Testbench for mlp_dram_loader: memory model, behavioural Top model and
// scoreboard queues filled from a reference address/data model.
module tb_mlp_dram_loader;

   localparam int L = 1104;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        mode;
   logic [15:0] ifmap_base, weight_base, bias_base, ofmap_base;
   logic        mem_req, mem_we, mem_gnt;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        top_ready, top_i_en, top_valid;
   logic [31:0] top_data_in, top_ofmap;
   logic        busy, done, err;

   always #5 clk = ~clk;

   mlp_dram_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .ifmap_base(ifmap_base), .weight_base(weight_base),
      .bias_base(bias_base), .ofmap_base(ofmap_base),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
      .top_ready(top_ready), .top_i_en(top_i_en), .top_data_in(top_data_in),
      .top_valid(top_valid), .top_ofmap(top_ofmap),
      .busy(busy), .done(done), .err(err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [15:0] a;
      logic [31:0] d;
   } wr_t;

   logic [15:0] exp_addr_q [$];
   logic [31:0] exp_data_q [$];
   wr_t         exp_wr_q   [$];

   logic [31:0] mem     [0:65535];
   logic [31:0] ref_mem [0:65535];

   function automatic logic [31:0] init_word(input int a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ a;
   endfunction

   // job configuration seen by the Top model
   logic        cfg_mode;
   logic [15:0] cfg_ib, cfg_wb, cfg_bb, cfg_ob;
   bit          cfg_ovf;
   int          tm_pass;
   bit          abort;
   int          gnt_mode;   // 0 always granted, 1 random, 2 never

   // monitor bookkeeping
   int  rd_grants = 0;
   int  done_cnt  = 0;
   int  run_len   = 0;
   int  max_run   = 0;
   bit  stall_prev = 0;
   logic        stall_we;
   logic [15:0] stall_addr;
   logic        prev_top_valid = 0;
   logic        busy_prev = 0;

   // memory model: read data returned one cycle after the grant
   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = init_word(a);
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         if (mem_req && mem_gnt) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata <= mem[mem_addr];
         end
      end
   end

   // grant generator
   initial begin
      gnt_mode = 0;
      mem_gnt  = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (gnt_mode)
            0:       mem_gnt = 1'b1;
            1:       mem_gnt = 1'($urandom_range(0, 1));
            default: mem_gnt = 1'b0;
         endcase
      end
   end

   task automatic push_rd(input logic [15:0] a);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(ref_mem[a]);
   endtask

   // expected read order of one pass, straight from the region/address rules
   task automatic build_pass(input int p);
      for (int k = 0; k < 16; k++)
         push_rd(cfg_ib + 16'(k) + (cfg_mode ? 16'(16 * p) : 16'd0));
      if (cfg_mode) begin
         for (int r = 0; r < 64; r++)
            for (int c = 0; c < 16; c++)
               push_rd(cfg_wb + 16'(32 * r + 16 * p + c));
      end else begin
         for (int k = 0; k < 1024; k++) push_rd(cfg_wb + 16'(1024 * p + k));
      end
      for (int k = 0; k < 64; k++) begin
         if (cfg_mode) push_rd(((p == 1) ? cfg_ob : cfg_bb) + 16'(k));
         else          push_rd(cfg_bb + 16'(64 * p + k));
      end
   endtask

   // behavioural Top: count 1104 beats after top_ready, then return 64 results
   initial begin
      int beats, guard, saved, gap;
      bit ovf_pass;
      logic [15:0] wa;
      for (int a = 0; a < 65536; a++) ref_mem[a] = init_word(a);
      top_valid = 1'b0;
      top_ofmap = '0;
      forever begin
         @(negedge clk);
         if (top_ready && !abort) begin
            build_pass(tm_pass);
            beats = 0;
            guard = 0;
            while (beats < L && !abort && guard < 20000) begin
               @(negedge clk);
               guard++;
               if (top_i_en) beats++;
            end
            if (!abort) begin
               check("load_beats", beats, L);
               ovf_pass = cfg_ovf && (tm_pass == 0);
               saved    = gnt_mode;
               gnt_mode = ovf_pass ? 2 : 0;
               repeat (2) @(posedge clk);
               for (int j = 0; j < 64; j++) begin
                  gap = (ovf_pass && j < 5) ? 0 : $urandom_range(0, 2);
                  if (ovf_pass && j == 5) gap = 8;
                  repeat (gap) begin
                     @(posedge clk); #1;
                     top_valid = 1'b0;
                  end
                  @(posedge clk); #1;
                  top_valid = 1'b1;
                  top_ofmap = $urandom;
                  if (!(ovf_pass && j == 4)) begin
                     wa = cfg_ob + 16'(64 * tm_pass + j);
                     exp_wr_q.push_back('{a: wa, d: top_ofmap});
                     ref_mem[wa] = top_ofmap;
                  end
                  if (ovf_pass && j == 4) begin
                     @(posedge clk); #1;
                     top_valid = 1'b0;
                     repeat (2) @(negedge clk);
                     check("ovf_err_set", err, 1);
                     check("ovf_head_held", {mem_req, mem_we}, 2'b11);
                     check("ovf_head_addr", mem_addr, cfg_ob);
                     // start while busy must not clear err or restart the job
                     @(posedge clk); #1;
                     start = 1'b1;
                     mode  = ~cfg_mode;
                     @(posedge clk); #1;
                     start = 1'b0;
                     repeat (2) @(negedge clk);
                     check("err_kept_on_busy_start", err, 1);
                     gnt_mode = 0;
                  end
               end
               @(posedge clk); #1;
               top_valid = 1'b0;
               gnt_mode  = saved;
               tm_pass++;
            end
         end
      end
   end

   // monitor: pops expectations whenever the DUT presents an output
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 0;
         run_len    = 0;
      end else begin
         if (stall_prev)
            check("stall_hold", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, stall_we, stall_addr}));
         if (mem_req && mem_gnt && !mem_we) begin
            rd_grants++;
            if (exp_addr_q.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_addr", mem_addr, exp_addr_q.pop_front());
         end
         if (mem_req && mem_gnt && mem_we) begin
            if (exp_wr_q.size() == 0) begin
               check("wr_unexpected", 1, 0);
            end else begin
               wr_t w;
               w = exp_wr_q.pop_front();
               check("wr_addr", mem_addr, w.a);
               check("wr_data", mem_wdata, w.d);
            end
         end
         if (top_i_en) begin
            if (exp_data_q.size() == 0) check("ien_unexpected", 1, 0);
            else check("ien_data", top_data_in, exp_data_q.pop_front());
            run_len++;
            if (run_len > max_run) max_run = run_len;
         end else begin
            run_len = 0;
         end
         if (top_ready) check("ready_after_valid_low", prev_top_valid, 0);
         if (done) begin
            done_cnt++;
            check("busy_falls_with_done", {busy_prev, busy}, 2'b10);
         end
         stall_prev = mem_req && !mem_gnt;
         stall_we   = mem_we;
         stall_addr = mem_addr;
      end
      prev_top_valid = top_valid;
      busy_prev      = busy;
   end

   task automatic set_cfg(input logic m, input logic [15:0] ib, wb, bb, ob, input bit ovf);
      cfg_mode = m;
      cfg_ib   = ib;
      cfg_wb   = wb;
      cfg_bb   = bb;
      cfg_ob   = ob;
      cfg_ovf  = ovf;
      tm_pass  = 0;
      abort    = 0;
   endtask

   task automatic issue_start(input bit hold_valid);
      @(posedge clk); #1;
      mode        = cfg_mode;
      ifmap_base  = cfg_ib;
      weight_base = cfg_wb;
      bias_base   = cfg_bb;
      ofmap_base  = cfg_ob;
      start       = 1'b1;
      if (hold_valid) top_valid = 1'b1;
      @(negedge clk);
      check("busy_before_accept", busy, 0);
      @(posedge clk); #1;
      start       = 1'b0;
      mode        = ~cfg_mode;
      ifmap_base  = 16'($urandom);
      weight_base = 16'($urandom);
      bias_base   = 16'($urandom);
      ofmap_base  = 16'($urandom);
      @(negedge clk);
      check("busy_after_start", busy, 1);
      check("err_cleared_on_start", err, 0);
      if (hold_valid) begin
         repeat (3) @(posedge clk);
         #1 top_valid = 1'b0;
      end
   endtask

   task automatic run_job(input logic m, input logic [15:0] ib, wb, bb, ob,
                          input int gm, input bit ovf, input bit hold_valid, input bit extra_start);
      int d0, guard;
      set_cfg(m, ib, wb, bb, ob, ovf);
      gnt_mode = gm;
      d0 = done_cnt;
      issue_start(hold_valid);
      if (extra_start) begin
         repeat (50) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      guard = 0;
      while (done_cnt == d0 && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      check("job_done", done_cnt - d0, 1);
      repeat (5) @(negedge clk);
      check("single_done", done_cnt - d0, 1);
      check("queues_drained", exp_addr_q.size() + exp_data_q.size() + exp_wr_q.size(), 0);
      check("idle_after_job", {busy, mem_req}, 2'b00);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, guard;
      rst_n = 1'b0; start = 1'b0; mode = 1'b0;
      ifmap_base = '0; weight_base = '0; bias_base = '0; ofmap_base = '0;
      abort = 0; cfg_ovf = 0; tm_pass = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl", {mem_req, mem_we, top_ready, top_i_en, busy, done, err}, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_data_in", top_data_in, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // mode 0, always granted, top_valid held high across the start
      max_run = 0;
      run_job(1'b0, 16'h0000, 16'h0100, 16'h0900, 16'h0A00, 0, 0, 1, 0);
      check("gnt1_consecutive_beats", max_run, L);
      check("err_clear_after_clean_job", err, 0);

      // mode 1 with random grants and an ignored mid-job start
      run_job(1'b1, 16'h0000, 16'h0100, 16'h0900, 16'h0A00, 1, 0, 0, 1);

      // write FIFO overflow during pass 0 collection
      run_job(1'b0, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 0, 1, 0, 0);
      check("err_sticky_after_job", err, 1);

      // reset in the middle of the load phase
      set_cfg(1'b0, 16'h0000, 16'h0100, 16'h0900, 16'h0A00, 0);
      gnt_mode = 0;
      r0 = rd_grants;
      issue_start(0);
      check("err_cleared_by_new_job", err, 0);
      guard = 0;
      while (rd_grants - r0 < 500 && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      check("reached_read_500", (rd_grants - r0 >= 500), 1);
      #1 rst_n = 1'b0;
      abort = 1;
      #1;
      check("midrst_ctrl", {mem_req, mem_we, top_ready, top_i_en, busy, done, err}, 0);
      check("midrst_addr", mem_addr, 0);
      check("midrst_wdata", mem_wdata, 0);
      check("midrst_data_in", top_data_in, 0);
      exp_addr_q.delete();
      exp_data_q.delete();
      exp_wr_q.delete();
      repeat (3) begin
         @(negedge clk);
         check("no_req_in_reset", {mem_req, top_i_en}, 0);
      end
      @(posedge clk); #1 rst_n = 1'b1;

      // restart from read 0 with random bases (address wrap included)
      run_job(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1, 0, 0, 0);
      check("err_clear_final", err, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
